// File: rtl/sp_if_mch_pkg.sv
// Shared types and helpers for the multi-channel DDR control sequencer.
package sp_if_mch_pkg;

    // Per-channel sequence state
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_SP,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_DONE
    } ch_state_e;

    // Channel index width, never below one bit
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // base + frame * offset in 32 bits; callers truncate to the DDR address width
    function automatic logic [31:0] calc_addr(input logic [31:0] base,
                                              input logic [31:0] frame,
                                              input logic [31:0] ofs);
        return base + frame * ofs;
    endfunction

endpackage

// File: rtl/sp_if_mch_ch_fsm.sv
// One control channel: read -> signal-process -> write sequence, frame
// counter and sticky overflow flag. The arbiter lives in the top.
module sp_if_mch_ch_fsm
    import sp_if_mch_pkg::*;
#(
    parameter int FRAME_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               startp,
    input  logic               sp_end,
    input  logic               gnt,
    input  logic               ddr_endp,
    input  logic               ovf_clr,
    input  logic               sync_on,
    input  logic [FRAME_W-1:0] frame_max,
    output logic               req,
    output logic               wr_req,
    output logic               sp_start,
    output logic               ctrl_endp,
    output logic               busy,
    output logic               ovf,
    output logic [FRAME_W-1:0] frame
);

    ch_state_e          state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               ovf_q, ovf_d;
    logic               sp_start_q, sp_start_d;

    // State, frame counter, overflow and sp_start registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            ovf_q      <= 1'b0;
            sp_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            ovf_q      <= ovf_d;
            sp_start_q <= sp_start_d;
        end
    end

    // Next-state; a start while busy (DONE included) is dropped and flagged,
    // and a same-cycle clear loses to the set
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        ovf_d      = ovf_q;
        sp_start_d = 1'b0;
        if (ovf_clr)
            ovf_d = 1'b0;
        if (startp && state_q != ST_IDLE)
            ovf_d = 1'b1;
        case (state_q)
            ST_IDLE:    if (startp)   state_d = ST_RD_REQ;
            ST_RD_REQ:  if (gnt)      state_d = ST_RD_WAIT;
            ST_RD_WAIT: if (ddr_endp) begin
                            state_d    = ST_SP;
                            sp_start_d = 1'b1;
                        end
            ST_SP:      if (sp_end)   state_d = ST_WR_REQ;
            ST_WR_REQ:  if (gnt)      state_d = ST_WR_WAIT;
            ST_WR_WAIT: if (ddr_endp) state_d = ST_DONE;
            ST_DONE: begin
                // >= also catches frame_max lowered below the running count
                frame_d = (frame_q >= frame_max) ? '0 : frame_q + 1'b1;
                state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    assign req       = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
    assign wr_req    = (state_q == ST_WR_REQ);
    assign sp_start  = sp_start_q;
    assign ctrl_endp = (state_q == ST_DONE) && !sync_on;
    assign busy      = (state_q != ST_IDLE);
    assign ovf       = ovf_q;
    assign frame     = frame_q;

endmodule

// File: rtl/sp_if_ctrl_ddr_mch.sv
// Multi-channel DDR control sequencer: CH_NUM channel FSMs sharing one DDR
// command port through a round-robin arbiter with one access outstanding.
// Optional macro SP_IF_MCH_RATEDOWN_EN adds i_sync_on to suppress o_ctrl_endp.
module sp_if_ctrl_ddr_mch
    import sp_if_mch_pkg::*;
#(
    parameter  int CH_NUM  = 4,
    parameter  int FRAME_W = 4,
    parameter  int ADDR_W  = 27,
    parameter  int SIZE_W  = 32,
    localparam int CH_W    = ch_w(CH_NUM)
) (
    input  logic                      i_clk156m,
    input  logic                      i_arst,
    input  logic [CH_NUM*FRAME_W-1:0] i_frame_max,
    input  logic [CH_NUM*32-1:0]      i_frame_offset,
    input  logic [CH_NUM*ADDR_W-1:0]  i_rd_base,
    input  logic [CH_NUM*ADDR_W-1:0]  i_wr_base,
    input  logic [CH_NUM*SIZE_W-1:0]  i_rd_size,
    input  logic [CH_NUM*SIZE_W-1:0]  i_wr_size,
    input  logic [CH_NUM-1:0]         i_ctrl_startp,
    input  logic [CH_NUM-1:0]         i_sp_end,
    input  logic                      i_ddr_endp,
    input  logic                      i_ovf_clr,
`ifdef SP_IF_MCH_RATEDOWN_EN
    input  logic [CH_NUM-1:0]         i_sync_on,
`endif
    output logic [CH_NUM*FRAME_W-1:0] o_frame_time,
    output logic                      o_ddr_wxr,
    output logic [CH_W-1:0]           o_ddr_ch,
    output logic [ADDR_W-1:0]         o_ddr_addr,
    output logic [SIZE_W-1:0]         o_ddr_size,
    output logic                      o_ddr_start,
    output logic [CH_NUM-1:0]         o_ddr_endp,
    output logic [CH_NUM-1:0]         o_sp_start,
    output logic [CH_NUM-1:0]         o_ctrl_endp,
    output logic [CH_NUM-1:0]         o_busy,
    output logic [CH_NUM-1:0]         o_ovf
);

    logic [CH_NUM-1:0][FRAME_W-1:0] frame_max_a, frame_a;
    logic [CH_NUM-1:0][31:0]        ofs_a;
    logic [CH_NUM-1:0][ADDR_W-1:0]  rd_base_a, wr_base_a;
    logic [CH_NUM-1:0][SIZE_W-1:0]  rd_size_a, wr_size_a;
    logic [CH_NUM-1:0]              req, wr_req, gnt, ch_endp, sync_on;

    assign frame_max_a  = i_frame_max;
    assign ofs_a        = i_frame_offset;
    assign rd_base_a    = i_rd_base;
    assign wr_base_a    = i_wr_base;
    assign rd_size_a    = i_rd_size;
    assign wr_size_a    = i_wr_size;
    assign o_frame_time = frame_a;

`ifdef SP_IF_MCH_RATEDOWN_EN
    assign sync_on = i_sync_on;
`else
    assign sync_on = '0;
`endif

    logic              acc_q, acc_d;         // an access is outstanding
    logic [CH_W-1:0]   ptr_q, ptr_d;         // last granted channel
    logic              start_q, start_d;
    logic              wxr_q, wxr_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [CH_NUM-1:0] dendp_q, dendp_d;

    logic              found;
    logic [CH_W-1:0]   sel;

    // Route the completion to whichever channel owns the outstanding access
    always_comb begin
        ch_endp = '0;
        if (acc_q && i_ddr_endp)
            ch_endp[ch_q] = 1'b1;
    end

    generate
        for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
            sp_if_mch_ch_fsm #(.FRAME_W(FRAME_W)) u_ch (
                .clk       (i_clk156m),
                .rst       (i_arst),
                .startp    (i_ctrl_startp[g]),
                .sp_end    (i_sp_end[g]),
                .gnt       (gnt[g]),
                .ddr_endp  (ch_endp[g]),
                .ovf_clr   (i_ovf_clr),
                .sync_on   (sync_on[g]),
                .frame_max (frame_max_a[g]),
                .req       (req[g]),
                .wr_req    (wr_req[g]),
                .sp_start  (o_sp_start[g]),
                .ctrl_endp (o_ctrl_endp[g]),
                .busy      (o_busy[g]),
                .ovf       (o_ovf[g]),
                .frame     (frame_a[g])
            );
        end
    endgenerate

    // Round-robin search starting just after the last granted channel
    always_comb begin
        logic [CH_W-1:0] idx;
        found = 1'b0;
        sel   = ptr_q;
        for (int i = 1; i <= CH_NUM; i++) begin
            idx = CH_W'((int'(ptr_q) + i) % CH_NUM);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // Grant only with the port free; an end pulse frees it for the next cycle,
    // so a request meeting i_ddr_endp is decided one cycle later
    always_comb begin
        acc_d   = acc_q;
        ptr_d   = ptr_q;
        start_d = 1'b0;
        wxr_d   = wxr_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        size_d  = size_q;
        gnt     = '0;
        dendp_d = ch_endp;
        if (acc_q) begin
            if (i_ddr_endp)
                acc_d = 1'b0;
        end else if (found) begin
            gnt[sel] = 1'b1;
            acc_d    = 1'b1;
            ptr_d    = sel;
            start_d  = 1'b1;
            wxr_d    = wr_req[sel];
            ch_d     = sel;
            // frame is still the pre-DONE value for the write access
            if (wr_req[sel]) begin
                addr_d = ADDR_W'(calc_addr(32'(wr_base_a[sel]), 32'(frame_a[sel]), ofs_a[sel]));
                size_d = wr_size_a[sel];
            end else begin
                addr_d = ADDR_W'(calc_addr(32'(rd_base_a[sel]), 32'(frame_a[sel]), ofs_a[sel]));
                size_d = rd_size_a[sel];
            end
        end
    end

    // Arbiter and DDR command registers
    always_ff @(posedge i_clk156m or posedge i_arst) begin
        if (i_arst) begin
            acc_q   <= 1'b0;
            ptr_q   <= CH_W'(CH_NUM - 1);
            start_q <= 1'b0;
            wxr_q   <= 1'b0;
            ch_q    <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            dendp_q <= '0;
        end else begin
            acc_q   <= acc_d;
            ptr_q   <= ptr_d;
            start_q <= start_d;
            wxr_q   <= wxr_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            dendp_q <= dendp_d;
        end
    end

    assign o_ddr_start = start_q;
    assign o_ddr_wxr   = wxr_q;
    assign o_ddr_ch    = ch_q;
    assign o_ddr_addr  = addr_q;
    assign o_ddr_size  = size_q;
    assign o_ddr_endp  = dendp_q;

endmodule

// File: tb/tb_sp_if_ctrl_ddr_mch.sv
// Directed bench for sp_if_ctrl_ddr_mch: a cycle table for one full
// sequence, then hand-written frame-wrap, overflow, reset and contention runs.
module tb_sp_if_ctrl_ddr_mch;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [15:0] frame_max  = {4'd2, 4'd2, 4'd2, 4'd2};
    logic [127:0] frame_ofs = {32'h100, 32'h100, 32'h100, 32'h100};
    logic [107:0] rd_base   = {27'h400000, 27'h300000, 27'h200000, 27'h100000};
    logic [107:0] wr_base   = {27'h1300000, 27'h1200000, 27'h1100000, 27'h1000000};
    logic [127:0] rd_size   = {32'h43, 32'h42, 32'h41, 32'h40};
    logic [127:0] wr_size   = {32'h83, 32'h82, 32'h81, 32'h80};
    logic [3:0]  startp = '0, sp_end = '0;
    logic        dendp_in = 1'b0, ovf_clr = 1'b0;
    logic [3:0]  sync_on = '0;

    logic [15:0] o_frame_time;
    logic        o_ddr_wxr, o_ddr_start;
    logic [1:0]  o_ddr_ch;
    logic [26:0] o_ddr_addr;
    logic [31:0] o_ddr_size;
    logic [3:0]  o_ddr_endp, o_sp_start, o_ctrl_endp, o_busy, o_ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sp_if_ctrl_ddr_mch #(.CH_NUM(4), .FRAME_W(4), .ADDR_W(27), .SIZE_W(32)) dut (
        .i_clk156m      (clk),
        .i_arst         (arst),
        .i_frame_max    (frame_max),
        .i_frame_offset (frame_ofs),
        .i_rd_base      (rd_base),
        .i_wr_base      (wr_base),
        .i_rd_size      (rd_size),
        .i_wr_size      (wr_size),
        .i_ctrl_startp  (startp),
        .i_sp_end       (sp_end),
        .i_ddr_endp     (dendp_in),
        .i_ovf_clr      (ovf_clr),
`ifdef SP_IF_MCH_RATEDOWN_EN
        .i_sync_on      (sync_on),
`endif
        .o_frame_time   (o_frame_time),
        .o_ddr_wxr      (o_ddr_wxr),
        .o_ddr_ch       (o_ddr_ch),
        .o_ddr_addr     (o_ddr_addr),
        .o_ddr_size     (o_ddr_size),
        .o_ddr_start    (o_ddr_start),
        .o_ddr_endp     (o_ddr_endp),
        .o_sp_start     (o_sp_start),
        .o_ctrl_endp    (o_ctrl_endp),
        .o_busy         (o_busy),
        .o_ovf          (o_ovf)
    );

    typedef struct packed {
        logic        ds;
        logic        wxr;
        logic [1:0]  ch;
        logic [26:0] addr;
        logic [31:0] size;
        logic [3:0]  sps, de, ce, busy, ovf;
        logic [15:0] frame;
    } obs_t;

    typedef struct packed {
        logic [3:0] startp;
        logic [3:0] sp_end;
        logic       dendp;
        logic       clr;
        obs_t       exp;
    } vec_t;

    obs_t obs;
    assign obs = {o_ddr_start, o_ddr_wxr, o_ddr_ch, o_ddr_addr, o_ddr_size,
                  o_sp_start, o_ddr_endp, o_ctrl_endp, o_busy, o_ovf, o_frame_time};

    vec_t tbl[$];

    logic [26:0] rd_b [4] = '{27'h100000, 27'h200000, 27'h300000, 27'h400000};
    logic [26:0] wr_b [4] = '{27'h1000000, 27'h1100000, 27'h1200000, 27'h1300000};

    function automatic obs_t mo(input logic ds, input logic wxr, input logic [1:0] ch,
                                input logic [26:0] addr, input logic [31:0] size,
                                input logic [3:0] sps, input logic [3:0] de,
                                input logic [3:0] ce, input logic [3:0] busy,
                                input logic [3:0] ovf, input logic [15:0] frame);
        return {ds, wxr, ch, addr, size, sps, de, ce, busy, ovf, frame};
    endfunction

    task automatic add(input logic [3:0] st, input logic [3:0] se, input logic de,
                       input logic clr, input obs_t e);
        tbl.push_back({st, se, de, clr, e});
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance to the next falling edge and drop all pulse inputs
    task automatic step();
        @(negedge clk);
        startp   = '0;
        sp_end   = '0;
        dendp_in = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        do begin
            step();
            n++;
        end while (!o_ddr_start && n < 30);
        if (!o_ddr_start) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: o_ddr_start got 0 expected 1 within 30 cycles", nm);
        end
    endtask

    task automatic wait_sp(input logic [1:0] ch);
        int n = 0;
        do begin
            step();
            n++;
        end while (!o_sp_start[ch] && n < 30);
        if (!o_sp_start[ch]) begin
            n_vec++;
            n_err++;
            $display("FAIL sp_start_wait: ch %0d got 0 expected 1 within 30 cycles", ch);
        end
    endtask

    // One full sequence on a channel, checking both access addresses and the end pulse
    task automatic run_seq(input logic [1:0] ch, input logic [26:0] rd, input logic [26:0] wr,
                           input logic exp_ce);
        logic seen;
        step();
        startp[ch] = 1'b1;
        wait_start("seq_rd");
        chk("seq_rd", 128'({o_ddr_ch, o_ddr_wxr, o_ddr_addr}), 128'({ch, 1'b0, rd}));
        dendp_in = 1'b1;
        wait_sp(ch);
        sp_end[ch] = 1'b1;
        wait_start("seq_wr");
        chk("seq_wr", 128'({o_ddr_ch, o_ddr_wxr, o_ddr_addr}), 128'({ch, 1'b1, wr}));
        dendp_in = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            step();
            seen = seen | o_ctrl_endp[ch];
        end
        chk("seq_ctrl_endp", 128'(seen), 128'(exp_ce));
    endtask

    initial begin
        // single channel 0, frame 0: startp -> read -> sp -> write -> done,
        // then stray ddr_endp / sp_end with nothing pending
        add(4'b0001, 4'b0000, 0, 0, mo(0,0,0,27'h0,      32'h0, 0,0,0,4'b0000,0,16'h0000));
        add(4'b0000, 4'b0000, 0, 0, mo(0,0,0,27'h0,      32'h0, 0,0,0,4'b0001,0,16'h0000));
        add(4'b0000, 4'b0000, 0, 0, mo(1,0,0,27'h100000, 32'h40,0,0,0,4'b0001,0,16'h0000));
        add(4'b0000, 4'b0000, 1, 0, mo(0,0,0,27'h100000, 32'h40,0,0,0,4'b0001,0,16'h0000));
        add(4'b0000, 4'b0001, 0, 0, mo(0,0,0,27'h100000, 32'h40,4'b0001,4'b0001,0,4'b0001,0,16'h0000));
        add(4'b0000, 4'b0000, 0, 0, mo(0,0,0,27'h100000, 32'h40,0,0,0,4'b0001,0,16'h0000));
        add(4'b0000, 4'b0000, 1, 0, mo(1,1,0,27'h1000000,32'h80,0,0,0,4'b0001,0,16'h0000));
        add(4'b0000, 4'b0000, 0, 0, mo(0,1,0,27'h1000000,32'h80,0,4'b0001,4'b0001,4'b0001,0,16'h0000));
        add(4'b0000, 4'b0001, 1, 0, mo(0,1,0,27'h1000000,32'h80,0,0,0,4'b0000,0,16'h0001));
        add(4'b0000, 4'b0000, 0, 0, mo(0,1,0,27'h1000000,32'h80,0,0,0,4'b0000,0,16'h0001));

        repeat (3) @(negedge clk);
        arst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step();
            chk($sformatf("tbl[%0d]", i), 128'(obs), 128'(tbl[i].exp));
            startp   = tbl[i].startp;
            sp_end   = tbl[i].sp_end;
            dendp_in = tbl[i].dendp;
            ovf_clr  = tbl[i].clr;
        end

        // frame wrap with frame_max=2: frames 1, 2, 0, 1
        run_seq(2'd0, 27'h100100, 27'h1000100, 1'b1);
        run_seq(2'd0, 27'h100200, 27'h1000200, 1'b1);
        run_seq(2'd0, 27'h100000, 27'h1000000, 1'b1);
        run_seq(2'd0, 27'h100100, 27'h1000100, 1'b1);

        // overflow on channel 1
        step();
        startp[1] = 1'b1;
        wait_start("ovf_rd");
        chk("ovf_rd", 128'({o_ddr_ch, o_ddr_wxr, o_ddr_addr}), 128'({2'd1, 1'b0, 27'h200000}));
        dendp_in = 1'b1;
        step();
        chk("ovf_sp", 128'(o_sp_start), 128'(4'b0010));
        startp[1] = 1'b1;
        step();
        chk("ovf_set", 128'({o_ddr_start, o_ovf, o_busy}), 128'({1'b0, 4'b0010, 4'b0010}));
        sp_end[1] = 1'b1;
        step();
        startp[1] = 1'b1;
        ovf_clr   = 1'b1;
        step();
        chk("ovf_setwins", 128'({o_ddr_start, o_ddr_wxr, o_ddr_addr, o_ovf}),
            128'({1'b1, 1'b1, 27'h1100000, 4'b0010}));
        dendp_in = 1'b1;
        ovf_clr  = 1'b1;
        step();
        chk("ovf_clr_done", 128'({o_ctrl_endp, o_ovf}), 128'({4'b0010, 4'b0000}));
        startp[1] = 1'b1;
        step();
        chk("ovf_in_done", 128'({o_busy, o_ovf, o_frame_time}), 128'({4'b0000, 4'b0010, 16'h0012}));
        ovf_clr = 1'b1;
        step();
        chk("ovf_clear", 128'(o_ovf), 128'(4'b0000));

        // reset while channel 2's read is outstanding
        step();
        startp[2] = 1'b1;
        wait_start("rst_rd");
        chk("rst_rd", 128'({o_ddr_ch, o_ddr_wxr, o_ddr_addr}), 128'({2'd2, 1'b0, 27'h300000}));
        arst = 1'b1;
        #1;
        chk("rst_outputs", 128'(obs), 128'(0));
        step();
        step();
        arst = 1'b0;

        // contention after reset: reads 0..3, then writes in round-robin order
        step();
        startp = 4'b1111;
        for (int g = 0; g < 8; g++) begin
            logic [1:0] c;
            logic       w;
            c = 2'(g % 4);
            w = (g >= 4);
            wait_start("grant");
            chk($sformatf("grant[%0d]", g), 128'({o_ddr_ch, o_ddr_wxr, o_ddr_addr, o_ddr_size}),
                128'({c, w, w ? wr_b[c] : rd_b[c], w ? 32'h80 + 32'(c) : 32'h40 + 32'(c)}));
            dendp_in = 1'b1;
            if (!w) begin
                step();
                sp_end[c] = 1'b1;
            end
        end
        repeat (3) step();
        chk("cont_end", 128'({o_busy, o_frame_time}), 128'({4'b0000, 16'h1111}));

`ifdef SP_IF_MCH_RATEDOWN_EN
        sync_on = 4'b0100;
        run_seq(2'd2, 27'h300100, 27'h1200100, 1'b0);
        sync_on = 4'b0000;
        chk("sync_frame", 128'(o_frame_time[11:8]), 128'(4'd2));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
